// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch resolution controller.
// Holds the controller state enum, RV32I branch condition codes and the PC step.
package branch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_REDIRECT,
      ST_FLUSH
   } state_t;

   localparam logic [2:0] COND_EQ  = 3'd0;
   localparam logic [2:0] COND_NE  = 3'd1;
   localparam logic [2:0] COND_LT  = 3'd2;
   localparam logic [2:0] COND_GE  = 3'd3;
   localparam logic [2:0] COND_LTU = 3'd4;
   localparam logic [2:0] COND_GEU = 3'd5;

   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational RV32I branch condition evaluator.
// Computes all six relations once and selects by cond; codes 6/7 flag illegal.
module branch_cond_eval
   import branch_ctrl_pkg::*;
(
   input  logic [2:0]  cond,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        taken,
   output logic        illegal
);

   logic rel_eq;
   logic rel_lt;
   logic rel_ltu;

   assign rel_eq  = (a == b);
   assign rel_lt  = ($signed(a) < $signed(b));
   assign rel_ltu = (a < b);

   always_comb begin
      // NOTE: defaults first, so every path assigns every output and no latch is inferred.
      taken   = 1'b0;
      illegal = 1'b0;
      case (cond)
         COND_EQ:  taken = rel_eq;
         COND_NE:  taken = !rel_eq;
         COND_LT:  taken = rel_lt;
         COND_GE:  taken = !rel_lt;
         COND_LTU: taken = rel_ltu;
         COND_GEU: taken = !rel_ltu;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch/jump resolver: evaluate, compare with prediction, redirect and flush.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_cond,
   input  logic             br_is_jump,
   input  logic [31:0]      br_rs1,
   input  logic [31:0]      br_rs2,
   input  logic [31:0]      br_pc,
   input  logic [31:0]      br_offset,
   input  logic             br_pred_taken,
   output logic             res_valid,
   output logic             res_taken,
   output logic             res_mispredict,
   output logic             res_illegal,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [31:0]      redirect_pc,
   output logic             flush,
   output logic             stall,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispredicts
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   state_t      state;
   state_t      state_nxt;

   logic [2:0]  q_cond;
   logic        q_jump;
   logic [31:0] q_rs1;
   logic [31:0] q_rs2;
   logic [31:0] q_pc;
   logic [31:0] q_offset;
   logic        q_pred;
   logic [3:0]  flush_cnt;

   logic        eval_taken;
   logic        eval_illegal;
   logic        taken;
   logic        illegal;
   logic        mispredict;
   logic [31:0] target;
   logic [31:0] fallthrough;

   branch_cond_eval u_cond_eval (
      .cond    (q_cond),
      .a       (q_rs1),
      .b       (q_rs2),
      .taken   (eval_taken),
      .illegal (eval_illegal)
   );

   // Jumps override the condition; an illegal code only matters for real branches.
   assign taken       = q_jump | eval_taken;
   assign illegal     = !q_jump & eval_illegal;
   assign mispredict  = taken ^ q_pred;
   assign target      = q_pc + q_offset;
   assign fallthrough = q_pc + PC_INC;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: capture registers are pure datapath, only read after a load, so they carry no reset.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && br_valid) begin
         q_cond   <= br_cond;
         q_jump   <= br_is_jump;
         q_rs1    <= br_rs1;
         q_rs2    <= br_rs2;
         q_pc     <= br_pc;
         q_offset <= br_offset;
         q_pred   <= br_pred_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_pc <= '0;
         flush_cnt   <= '0;
      end else begin
         if (state == ST_EVAL) redirect_pc <= taken ? target : fallthrough;
         if (state == ST_REDIRECT && redirect_ready) flush_cnt <= FLUSH_LOAD;
         else if (state == ST_FLUSH)                 flush_cnt <= flush_cnt - 4'd1;
      end
   end

   always_comb begin
      state_nxt      = state;
      br_ready       = 1'b0;
      res_valid      = 1'b0;
      res_taken      = 1'b0;
      res_mispredict = 1'b0;
      res_illegal    = 1'b0;
      redirect_valid = 1'b0;
      flush          = 1'b0;
      case (state)
         ST_IDLE: begin
            br_ready = 1'b1;
            if (br_valid) state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            res_valid      = 1'b1;
            res_taken      = taken;
            res_mispredict = mispredict;
            res_illegal    = illegal;
            state_nxt      = mispredict ? ST_REDIRECT : ST_IDLE;
         end
         ST_REDIRECT: begin
            redirect_valid = 1'b1;
            if (redirect_ready) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            flush = 1'b1;
            if (flush_cnt == 4'd1) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign stall = !br_ready;

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (res_valid) begin
         stat_branches <= stat_branches + CNT_W'(1);
         if (res_mispredict) stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
   end
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule
